// File: rtl/tdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdmi_pkg
// Brief    : Shared sizes and types for the TDM input receiver.
// Revision : 1.0
// ============================================================================
package tdmi_pkg;
    localparam int NUM_CH     = 32;
    localparam int WORD_W     = 8;
    localparam int FRAME_BITS = NUM_CH * WORD_W;
    localparam int CH_W       = $clog2(NUM_CH);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    typedef logic [CH_W-1:0]   chan_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BIT_W-1:0]  bit_idx_t;
endpackage
`default_nettype wire

// File: rtl/tdmi_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : tdmi_frame_buf
// Brief    : 2x32x8 ping-pong frame buffer, cleared on reset, registered read.
// Revision : 1.0
// ============================================================================
module tdmi_frame_buf
    import tdmi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [CH_W-1:0]   wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [CH_W-1:0]   rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    // Flat storage indexed by {bank, addr}; held in flops so reset can clear it.
    logic [WORD_W-1:0] r_mem [0:2*NUM_CH-1];
    logic [WORD_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2*NUM_CH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (wr_en) begin
                r_mem[{wr_bank, wr_addr}] <= wr_data;
            end
            r_rd_data <= r_mem[{rd_bank, rd_addr}];
        end
    end

    assign rd_data = r_rd_data;
endmodule
`default_nettype wire

// File: rtl/tdmi.sv
`default_nettype none
// ============================================================================
// Module   : tdmi
// Brief    : TDM input receiver: 32 slots x 8 bits, fs-aligned, ping-pong store.
// Revision : 1.0
// ============================================================================
module tdmi
    import tdmi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              fs,
    input  logic              din,
    input  logic [CH_W-1:0]   rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic [CH_W-1:0]   word_chan,
    output logic              frame_done,
    output logic              sync_err,
    input  logic              scan_in0,
    input  logic              scan_in1,
    input  logic              scan_in2,
    input  logic              scan_in3,
    input  logic              scan_in4,
    input  logic              scan_enable,
    input  logic              test_mode,
    output logic              scan_out0,
    output logic              scan_out1,
    output logic              scan_out2,
    output logic              scan_out3,
    output logic              scan_out4
);
    logic              r_synced;
    logic [BIT_W-1:0]  r_bit_idx;
    logic [WORD_W-2:0] r_shift;
    logic              r_wr_bank;
    logic              r_word_valid;
    logic [WORD_W-1:0] r_word_data;
    logic [CH_W-1:0]   r_word_chan;
    logic              r_frame_done;
    logic              r_sync_err;

    logic [CH_W-1:0]   w_slot;
    logic [WORD_W-1:0] w_word;
    logic              w_lsb;
    logic              w_unused;

    assign w_slot = r_bit_idx[BIT_W-1:3];
    assign w_word = {r_shift, din};
    // An fs on an LSB position realigns instead of completing the word.
    assign w_lsb  = r_synced && !fs && (r_bit_idx[2:0] == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_synced     <= 1'b0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_wr_bank    <= 1'b0;
            r_word_valid <= 1'b0;
            r_word_data  <= '0;
            r_word_chan  <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            if (fs) begin
                r_sync_err <= r_synced && (r_bit_idx != '0);
                r_synced   <= 1'b1;
                r_bit_idx  <= BIT_W'(1);
                r_shift    <= {{(WORD_W-2){1'b0}}, din};
            end else if (r_synced) begin
                r_bit_idx <= r_bit_idx + BIT_W'(1);
                r_shift   <= {r_shift[WORD_W-3:0], din};
                if (w_lsb) begin
                    r_word_valid <= 1'b1;
                    r_word_data  <= w_word;
                    r_word_chan  <= w_slot;
                    if (w_slot == CH_W'(NUM_CH-1)) begin
                        r_frame_done <= 1'b1;
                        r_wr_bank    <= ~r_wr_bank;
                    end
                end
            end
        end
    end

    tdmi_frame_buf u_frame_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_lsb),
        .wr_bank (r_wr_bank),
        .wr_addr (w_slot),
        .wr_data (w_word),
        .rd_bank (~r_wr_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign word_valid = r_word_valid;
    assign word_data  = r_word_data;
    assign word_chan  = r_word_chan;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;

    // Scan chains are stitched during synthesis; RTL ties them off.
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;
    assign w_unused  = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};
endmodule
`default_nettype wire

// File: tb/tb_tdmi.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdmi
// Brief    : Scoreboard bench for tdmi: directed frames, resync, reset, scan.
// Revision : 1.0
// ============================================================================
module tb_tdmi;
    import tdmi_pkg::*;

    logic       clk = 1'b0;
    logic       reset, fs, din;
    logic [4:0] rd_addr;
    logic [7:0] rd_data, word_data;
    logic [4:0] word_chan;
    logic       word_valid, frame_done, sync_err;
    logic       scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic       scan_enable, test_mode;
    logic       scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    tdmi dut (
        .clk(clk), .reset(reset), .fs(fs), .din(din),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .word_valid(word_valid), .word_data(word_data), .word_chan(word_chan),
        .frame_done(frame_done), .sync_err(sync_err),
        .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
        .scan_in3(scan_in3), .scan_in4(scan_in4),
        .scan_enable(scan_enable), .test_mode(test_mode),
        .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
        .scan_out3(scan_out3), .scan_out4(scan_out4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] chan;
        logic [7:0] data;
        logic       last;
    } wexp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    wexp_t      word_q[$];
    logic [7:0] rd_q[$];
    int         fd_cycles[$];
    int         serr_count = 0;
    int         serr_cycle = -1;
    logic       rd_req = 1'b0;
    logic       rd_req_d = 1'b0;
    logic       scan_mode = 1'b0;
    int         fs1, fs4;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_d <= rd_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected words/reads whenever the DUT presents them.
    wexp_t      m_e;
    logic [7:0] m_r;
    always @(negedge clk) begin
        if (word_valid === 1'b1) begin
            if (word_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_unexpected: got chan %0d data %0h expected no word (cycle %0d)",
                         word_chan, word_data, cyc);
            end else begin
                m_e = word_q.pop_front();
                chk("word", {18'd0, frame_done, word_chan, word_data},
                    {18'd0, m_e.last, m_e.chan, m_e.data});
            end
        end
        if (frame_done === 1'b1) begin
            if (word_valid !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL frame_done_alone: got frame_done without word_valid expected coincident (cycle %0d)", cyc);
            end
            fd_cycles.push_back(cyc);
        end
        if (sync_err === 1'b1) begin
            serr_count++;
            serr_cycle = cyc;
        end
        if (rd_req_d) begin
            m_r = rd_q.pop_front();
            chk("rd_data", {24'd0, rd_data}, {24'd0, m_r});
        end
    end

    task automatic step(input logic f, input logic d, input logic rq,
                        input logic [4:0] ra, input logic [7:0] rexp);
        fs      = f;
        din     = d;
        rd_req  = rq;
        rd_addr = ra;
        if (rq) rd_q.push_back(rexp);
        if (scan_mode) begin
            scan_enable = ~scan_enable;
            {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = 5'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    // Slot n carries base+n; the first 32 bits also read addresses 0..31.
    task automatic send_frame(input logic [7:0] base, input logic with_fs, input int nbits,
                              input logic do_rd, input logic rd_zero, input logic [7:0] rd_base);
        int         s;
        int         b;
        logic [7:0] byt;
        logic [7:0] rexp;
        for (int k = 0; k < nbits; k++) begin
            s    = k / 8;
            b    = 7 - (k % 8);
            byt  = base + 8'(s);
            rexp = rd_zero ? 8'h00 : rd_base + 8'(k);
            if (b == 0) word_q.push_back('{chan: 5'(s), data: byt, last: (s == 31)});
            step(with_fs && (k == 0), byt[b], do_rd && (k < 32), 5'(k), rexp);
        end
        rd_req = 1'b0;
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < 32; a++) step(1'b0, 1'b1, 1'b1, 5'(a), 8'h00);
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
    endtask

    task automatic check_quiet(input string name);
        chk(name, {word_valid, frame_done, sync_err, word_chan, word_data, rd_data,
                   scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, 32'd0);
    endtask

    initial begin
        int fd_exp[4];
        reset = 1'b1; fs = 1'b0; din = 1'b0; rd_addr = '0;
        scan_in0 = 0; scan_in1 = 0; scan_in2 = 0; scan_in3 = 0; scan_in4 = 0;
        scan_enable = 1'b0; test_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_outputs");
        reset = 1'b0;

        // Unsynced idle: no words, buffers read back zero.
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
        read_all_zero();

        fs1 = cyc;
        send_frame(8'h10, 1'b1, 256, 1'b1, 1'b1, 8'h00);
        send_frame(8'hA0, 1'b0, 256, 1'b1, 1'b0, 8'h10);

        // Flywheel into a frame that is interrupted by fs at bit 100.
        send_frame(8'h30, 1'b0, 100, 1'b1, 1'b0, 8'hA0);
        fs4 = cyc;
        send_frame(8'h50, 1'b1, 256, 1'b1, 1'b0, 8'hA0);

        scan_mode = 1'b1;
        test_mode = 1'b1;
        send_frame(8'h70, 1'b0, 256, 1'b1, 1'b0, 8'h50);
        scan_mode = 1'b0;
        test_mode = 1'b0;
        scan_enable = 1'b0;

        // Reset in the middle of a frame.
        send_frame(8'h90, 1'b0, 130, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
        check_quiet("midreset_outputs");
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
        read_all_zero();

        chk("words_outstanding", 32'(word_q.size()), 32'd0);
        chk("reads_outstanding", 32'(rd_q.size()), 32'd0);
        chk("sync_err_count", 32'(serr_count), 32'd1);
        chk("sync_err_cycle", 32'(serr_cycle), 32'(fs4 + 1));
        fd_exp[0] = fs1 + 256;
        fd_exp[1] = fs1 + 512;
        fd_exp[2] = fs4 + 256;
        fd_exp[3] = fs4 + 512;
        chk("frame_done_count", 32'(fd_cycles.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < fd_cycles.size()) chk("frame_done_cycle", 32'(fd_cycles[i]), 32'(fd_exp[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
